// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Constants, helpers and types shared by the RV32I front end.
//                NOP_IR           - canonical no-op (addi x0,x0,0)
//                RESET_PC_DEFAULT - default first fetch address after reset
//                PC_ALIGN_MASK    - clears the byte offset of a PC
//                fetch_state_e    - instruction fetch FSM state type
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

   localparam logic [31:0] NOP_IR           = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request on the bus, waiting for imem_ready
      WAIT  = 2'd1,   // request accepted, waiting for the response
      HOLD  = 2'd2,   // instruction presented to decode
      DROP  = 2'd3    // response owed for a cancelled request
   } fetch_state_e;

   // Word-aligned version of a byte PC.
   function automatic logic [31:0] pc_align(input logic [31:0] pc_in);
      return pc_in & PC_ALIGN_MASK;
   endfunction

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc_in);
      return pc_in + PC_STEP;
   endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Registered output stage of the fetch unit. Holds the word,
//                its PC and the fault flag presented to decode.
//                While empty, ir reads NOP_IR and fetch_fault reads 0.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                load              - capture load_ir/load_pc/load_fault, set valid
//                consume           - decode took the entry, empty the buffer
//                clear             - discard the entry (redirect)
//                load_ir/pc/fault  - data to capture
//                if_valid, ir, pc, fetch_fault - registered outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        consume,
   input  logic        clear,
   input  logic [31:0] load_ir,
   input  logic [31:0] load_pc,
   input  logic        load_fault,
   output logic        if_valid,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        fetch_fault
);

   logic        valid_q, valid_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_q, pc_d;
   logic        fault_q, fault_d;

   // The controller never asserts load together with consume/clear; load
   // is given priority so a same-cycle fault entry cannot be lost.
   always_comb begin
      valid_d = valid_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      if (load) begin
         valid_d = 1'b1;
         ir_d    = load_ir;
         pc_d    = load_pc;
         fault_d = load_fault;
      end else if (clear || consume) begin
         // pc keeps its last value; only ir/fault have a defined idle value
         valid_d = 1'b0;
         ir_d    = NOP_IR;
         fault_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ir_q    <= NOP_IR;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   assign if_valid    = valid_q;
   assign ir          = ir_q;
   assign pc          = pc_q;
   assign fetch_fault = fault_q;

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : RV32I instruction fetch stage. Owns the fetch PC, issues one
//                outstanding word read at a time and hands each instruction
//                to decode over a valid/ready handshake. Redirects cancel
//                in-flight and held work; a cancelled response is absorbed
//                in DROP before the next request goes out.
//  Build macro : IF_MISALIGN_CHECK_EN - when defined, a redirect to a non
//                word-aligned target raises fetch_fault instead of fetching;
//                when undefined, redirect_pc[1:0] is ignored.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                redirect, redirect_pc          - PC redirect from later stages
//                imem_req, imem_addr, imem_ready - request channel
//                imem_rvalid, imem_rdata, imem_err - response channel
//                if_valid, id_ready             - handshake with decode
//                ir, pc, fetch_fault            - instruction presented to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic        if_valid,
   input  logic        id_ready,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        fetch_fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;

   logic         buf_load;
   logic         buf_consume;
   logic         buf_clear;
   logic [31:0]  buf_ir;
   logic [31:0]  buf_pc;
   logic         buf_fault;
   logic         owed_after;

`ifdef IF_MISALIGN_CHECK_EN
   // A fault entry can be presented while a cancelled response is still
   // owed; this remembers that the response must be absorbed before the
   // next request is issued.
   logic         pend_q, pend_d;
`endif

   // Gated by rst so nothing reaches the bus while reset is held.
   assign imem_req  = (state_q == FETCH) && !rst;
   assign imem_addr = fetch_pc_q;

   // A response is still owed after this edge if a request is accepted now,
   // or one was in flight and its response is not arriving this cycle.
   always_comb begin
      owed_after = ((state_q == FETCH) && imem_ready) ||
                   (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid);
`ifdef IF_MISALIGN_CHECK_EN
      if ((state_q == HOLD) && pend_q && !imem_rvalid) begin
         owed_after = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      buf_load    = 1'b0;
      buf_consume = 1'b0;
      buf_clear   = 1'b0;
      buf_ir      = imem_err ? NOP_IR : imem_rdata;
      buf_pc      = fetch_pc_q;
      buf_fault   = imem_err;
`ifdef IF_MISALIGN_CHECK_EN
      pend_d      = pend_q;
`endif

      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               buf_load = 1'b1;
               state_d  = HOLD;
            end
         end
         HOLD: begin
`ifdef IF_MISALIGN_CHECK_EN
            if (pend_q && imem_rvalid) begin
               pend_d = 1'b0;
            end
`endif
            if (id_ready) begin
               buf_consume = 1'b1;
               fetch_pc_d  = pc_next(fetch_pc_q);
               state_d     = FETCH;
`ifdef IF_MISALIGN_CHECK_EN
               // Hand the still-owed response over to DROP.
               if (pend_q && !imem_rvalid) begin
                  state_d = DROP;
               end
               pend_d = 1'b0;
`endif
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // Redirect overrides every other event of the cycle.
      if (redirect) begin
         buf_load    = 1'b0;
         buf_consume = 1'b0;
         buf_clear   = 1'b1;
         fetch_pc_d  = pc_align(redirect_pc);
         state_d     = owed_after ? DROP : FETCH;
`ifdef IF_MISALIGN_CHECK_EN
         pend_d = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            // Present the fault directly; fetch_pc keeps the aligned
            // target so the bus never sees a misaligned address.
            buf_clear = 1'b0;
            buf_load  = 1'b1;
            buf_ir    = NOP_IR;
            buf_pc    = redirect_pc;
            buf_fault = 1'b1;
            state_d   = HOLD;
            pend_d    = owed_after;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end
`endif

   fetch_buffer #(
      .RESET_PC (RESET_PC)
   ) u_fetch_buffer (
      .clk         (clk),
      .rst         (rst),
      .load        (buf_load),
      .consume     (buf_consume),
      .clear       (buf_clear),
      .load_ir     (buf_ir),
      .load_pc     (buf_pc),
      .load_fault  (buf_fault),
      .if_valid    (if_valid),
      .ir          (ir),
      .pc          (pc),
      .fetch_fault (fetch_fault)
   );

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. A directed cycle table
//                walks the documented scenarios; a randomized phase drives a
//                variable-latency memory and random redirects/back-pressure
//                and compares every delivered instruction against a memory
//                image addressed by the expected program order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
   import rv32i_pkg::*;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] ir;
   logic [31:0] pc;
   logic        fetch_fault;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .if_valid    (if_valid),
      .id_ready    (id_ready),
      .ir          (ir),
      .pc          (pc),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- table
   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        err;
      logic        idr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_ir;
      logic [31:0] e_pc;
      logic        e_fault;
      logic        chk_pc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rd, input logic [31:0] rp,
                      input logic rdy, input logic rv, input logic [31:0] rdat,
                      input logic er, input logic idr,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_ir, input logic [31:0] e_pc,
                      input logic e_fault, input logic chk_pc);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.rdy = rdy; v.rv = rv; v.rdata = rdat;
      v.err = er; v.idr = idr; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_ir = e_ir; v.e_pc = e_pc; v.e_fault = e_fault; v.chk_pc = chk_pc;
      tbl.push_back(v);
   endtask

   // ---------------------------------------------------------- memory image
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic mem_bad(input logic [31:0] a);
      return ((a >> 2) % 7) == 3;
   endfunction

   // ------------------------------------------------------ random-phase model
   logic [31:0] exp_pc;
   logic        busy;
   logic [31:0] resp_addr;
   int          cnt;
   int          deliveries;
   logic        hold_prev;
   logic [31:0] h_ir, h_pc;
   logic        h_fault;
   logic [31:0] r;

   localparam logic [31:0] N = NOP_IR;

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0; id_ready = 1'b0;
      repeat (2) @(posedge clk);

      //  rst rd rpc           rdy rv rdata         er idr  req addr          v  ir            pc            f  chkpc
      add(1, 0, 0,             0,  0, 0,            0, 1,   0, 0,            0, N,            0,            0, 1);
      add(0, 0, 0,             1,  0, 0,            0, 1,   1, 0,            0, N,            0,            0, 1);
      add(0, 0, 0,             1,  1, 32'h00500093, 0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 1,   0, 0,            1, 32'h00500093, 0,            0, 1);
      add(0, 0, 0,             1,  0, 0,            0, 1,   1, 4,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  1, 32'h00100113, 0, 0,   0, 0,            0, N,            0,            0, 0);
      for (int k = 0; k < 5; k++)
         add(0, 0, 0,          1,  0, 0,            0, 0,   0, 0,            1, 32'h00100113, 4,            0, 1);
      add(0, 0, 0,             1,  0, 0,            0, 1,   0, 0,            1, 32'h00100113, 4,            0, 1);
      add(0, 0, 0,             1,  0, 0,            0, 0,   1, 8,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  1, 32'h12345678, 1, 0,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 0,   0, 0,            1, N,            8,            1, 1);
      add(0, 0, 0,             0,  0, 0,            0, 1,   0, 0,            1, N,            8,            1, 1);
      add(0, 0, 0,             1,  0, 0,            0, 1,   1, 32'hC,        0, N,            0,            0, 0);
      add(0, 1, 32'h100,       0,  0, 0,            0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             1,  0, 0,            0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             1,  1, 32'hDEADBEEF, 0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 1,   1, 32'h100,      0, N,            0,            0, 0);
      add(0, 0, 0,             1,  0, 0,            0, 1,   1, 32'h100,      0, N,            0,            0, 0);
      add(0, 0, 0,             0,  1, 32'h00000033, 0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 1,   0, 0,            1, 32'h33,       32'h100,      0, 1);
      add(0, 1, 32'hFFFFFFFC,  0,  0, 0,            0, 1,   1, 32'h104,      0, N,            0,            0, 0);
      add(0, 0, 0,             1,  0, 0,            0, 1,   1, 32'hFFFFFFFC, 0, N,            0,            0, 0);
      add(0, 0, 0,             0,  1, 32'h00000093, 0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 1,   0, 0,            1, 32'h93,       32'hFFFFFFFC, 0, 1);
      add(0, 0, 0,             0,  0, 0,            0, 1,   1, 0,            0, N,            0,            0, 0);
      add(0, 1, 32'h200,       1,  0, 0,            0, 1,   1, 0,            0, N,            0,            0, 0);
      add(0, 1, 32'h300,       1,  1, 32'hBAD0BAD0, 0, 1,   0, 0,            0, N,            0,            0, 0);
      add(0, 0, 0,             0,  0, 0,            0, 1,   1, 32'h300,      0, N,            0,            0, 0);
      add(0, 1, 32'h102,       0,  0, 0,            0, 1,   1, 32'h300,      0, N,            0,            0, 0);
`ifdef IF_MISALIGN_CHECK_EN
      add(0, 0, 0,             0,  0, 0,            0, 0,   0, 0,            1, N,            32'h102,      1, 1);
`else
      add(0, 0, 0,             0,  0, 0,            0, 1,   1, 32'h100,      0, N,            0,            0, 0);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
         imem_ready = tbl[i].rdy; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
         imem_err = tbl[i].err; id_ready = tbl[i].idr;
         #1;
         check($sformatf("row%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
         check($sformatf("row%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
         check($sformatf("row%0d ir", i), ir, tbl[i].e_ir);
         check($sformatf("row%0d fetch_fault", i), {31'd0, fetch_fault}, {31'd0, tbl[i].e_fault});
         if (tbl[i].e_req) check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
         if (tbl[i].chk_pc) check($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      end

      // ------------------------------------------------ randomized phase
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
      @(negedge clk);
      exp_pc = RESET_PC_DEFAULT; busy = 1'b0; cnt = 0; deliveries = 0; hold_prev = 1'b0;
      resp_addr = '0; h_ir = '0; h_pc = '0; h_fault = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (!if_valid) begin
            check("idle ir", ir, NOP_IR);
            check("idle fault", {31'd0, fetch_fault}, 32'd0);
         end
         if (hold_prev) begin
            check("held valid", {31'd0, if_valid}, 32'd1);
            check("held ir", ir, h_ir);
            check("held pc", pc, h_pc);
            check("held fault", {31'd0, fetch_fault}, {31'd0, h_fault});
         end

         rst = 1'b0;
         redirect = ($urandom_range(0, 19) == 0);
         r = $urandom;
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | (r & 32'hF);
         else                           redirect_pc = r & 32'h0000_0FFF;
`ifdef IF_MISALIGN_CHECK_EN
         redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
         id_ready   = ($urandom_range(0, 2) != 0);
         imem_ready = ($urandom_range(0, 1) == 1);
         if (busy && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_addr);
            imem_err    = mem_bad(resp_addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            imem_err    = ($urandom_range(0, 1) == 1);
            if (busy) cnt--;
         end
         #1;

         if (imem_req && imem_ready) begin
            check("single outstanding", {31'd0, busy}, 32'd0);
            check("fetch addr", imem_addr, exp_pc);
         end
         if (imem_rvalid) busy = 1'b0;
         if (imem_req && imem_ready) begin
            busy = 1'b1;
            resp_addr = imem_addr;
            cnt = $urandom_range(0, 2);
         end

         if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (if_valid && id_ready) begin
            check("deliver pc", pc, exp_pc);
            check("deliver ir", ir, mem_bad(exp_pc) ? NOP_IR : mem_word(exp_pc));
            check("deliver fault", {31'd0, fetch_fault}, {31'd0, mem_bad(exp_pc)});
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end

         hold_prev = if_valid && !id_ready && !redirect;
         h_ir = ir; h_pc = pc; h_fault = fetch_fault;
      end

      n_vec++;
      if (deliveries < 200) begin
         n_bad++;
         $display("FAIL progress: got %0d deliveries, expected at least 200", deliveries);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_if_stage
`default_nettype wire
